// File: rtl/axis_collector.sv
// Packet-granular round-robin merge of NUM_CH AXI-Stream sources into one
// registered output stream; the source index travels on m_axis_tuser.
//
// state  | meaning
// IDLE   | no grant held; pick the next enabled requester after rr_ptr
// LOCKED | grant held on one channel until its tlast beat is accepted
module axis_collector #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 256,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [IDX_W-1:0]         m_axis_tuser,
  input  logic                     m_axis_tready
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   en_q;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [IDX_W-1:0]    tuser_q, tuser_d;

  logic [NUM_CH-1:0]   req;
  logic [IDX_W-1:0]    rr_pick, cand;
  logic                rr_found;
  logic                out_free, accept;
  logic [DATA_W-1:0]   beat_data;

  assign req       = s_axis_tvalid & en_q;
  assign out_free  = !tvalid_q || m_axis_tready;
  assign accept    = (state_q == LOCKED) && out_free && s_axis_tvalid[grant_q];
  assign beat_data = s_axis_tdata[grant_q*DATA_W +: DATA_W];

  // Search starts one past the last served channel and wraps.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!rr_found && req[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    s_axis_tready = '0;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    tvalid_d      = m_axis_tready ? 1'b0 : tvalid_q;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        s_axis_tready[grant_q] = out_free;
        if (accept) begin
          tvalid_d = 1'b1;
          tdata_d  = beat_data;
          tlast_d  = s_axis_tlast[grant_q];
          tuser_d  = grant_q;
          if (s_axis_tlast[grant_q]) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= RR_RESET;
      en_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      en_q     <= channel_enable;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_collector.sv
// Scoreboard bench for axis_collector: per-channel source queues feed the DUT,
// expected beats are queued in predicted order and checked as they leave.
module tb_axis_collector;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 256;
  localparam int IDX_W  = 4;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        channel_enable;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic [IDX_W-1:0]         m_axis_tuser;
  logic                     m_axis_tready;

  axis_collector #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn), .channel_enable(channel_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [IDX_W-1:0]  user;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } sbeat_t;

  beat_t  exp_q[$];
  sbeat_t src_q[NUM_CH][$];
  int     out_cyc[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source model: pop a beat after its handshake, present the queue head.
  initial begin
    logic [NUM_CH-1:0] fire;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (fire[ch] && src_q[ch].size() > 0) void'(src_q[ch].pop_front());
        if (src_q[ch].size() > 0) begin
          s_axis_tvalid[ch] = 1'b1;
          s_axis_tlast[ch]  = src_q[ch][0].last;
          s_axis_tdata[ch*DATA_W +: DATA_W] = src_q[ch][0].data;
        end else begin
          s_axis_tvalid[ch] = 1'b0;
          s_axis_tlast[ch]  = 1'b0;
          s_axis_tdata[ch*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // Output monitor: scoreboard compare, hold-while-stalled and ready checks.
  initial begin
    logic  stall;
    beat_t held, got, want;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        got = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
        if (stall) begin
          vectors++;
          if (m_axis_tvalid !== 1'b1 || got !== held) begin
            miscompares++;
            $display("FAIL hold: got v=%b u=%0d l=%b d=%h want v=1 u=%0d l=%b d=%h",
                     m_axis_tvalid, got.user, got.last, got.data, held.user, held.last, held.data);
          end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0) begin
          vectors++;
          if (s_axis_tready !== '0) begin
            miscompares++;
            $display("FAIL stall_ready: got s_tready=%h want 0", s_axis_tready);
          end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          vectors++;
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got u=%0d l=%b d=%h want none", got.user, got.last, got.data);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              miscompares++;
              $display("FAIL beat: got u=%0d l=%b d=%h want u=%0d l=%b d=%h",
                       got.user, got.last, got.data, want.user, want.last, want.data);
            end
          end
        end
        stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
        held  = got;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input int ch, input int n, input bit expect_out);
    logic [DATA_W-1:0] d;
    for (int b = 0; b < n; b++) begin
      d = {8{$urandom()}};
      src_q[ch].push_back('{data: d, last: (b == n - 1)});
      if (expect_out) exp_q.push_back('{data: d, last: (b == n - 1), user: IDX_W'(ch)});
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    for (int ch = 0; ch < NUM_CH; ch++) src_q[ch].delete();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_enable(input logic [NUM_CH-1:0] en);
    @(negedge clk);
    channel_enable = en;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_gaps(input string name, input int first_exp, input int t0, input int pkt_len);
    vectors++;
    if (out_cyc[0] != t0 + first_exp) begin
      miscompares++;
      $display("FAIL %s_first: got cycle %0d want %0d", name, out_cyc[0] - t0, first_exp);
    end
    for (int i = 0; i + 1 < out_cyc.size(); i++) begin
      vectors++;
      if (out_cyc[i+1] - out_cyc[i] != (((i + 1) % pkt_len == 0) ? 2 : 1)) begin
        miscompares++;
        $display("FAIL %s_gap%0d: got %0d want %0d", name, i, out_cyc[i+1] - out_cyc[i],
                 ((i + 1) % pkt_len == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    channel_enable = '0;
    m_axis_tready = 1'b0;
    clear_queues();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    channel_enable = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== '0 || m_axis_tdata !== '0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b l=%b u=%0d d=%h want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    vectors++;
    if (s_axis_tready !== '0) begin
      miscompares++;
      $display("FAIL reset_sready: got %h want 0", s_axis_tready);
    end
  endtask

  task automatic test_single_packet();
    int t0, nout;
    do_reset();
    m_axis_tready = 1'b1;
    set_enable(16'h0008);
    out_cyc.delete();
    t0 = cyc;
    push_pkt(3, 4, 1'b1);
    wait_drain(50, "single");
    nout = out_cyc.size();
    vectors++;
    if (nout != 4) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 4", nout);
    end else begin
      check_gaps("single", 3, t0, 4);
    end
  endtask

  task automatic test_round_robin();
    int nout;
    do_reset();
    m_axis_tready = 1'b1;
    set_enable(16'hFFFF);
    out_cyc.delete();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2, 1'b1);
      push_pkt(5, 2, 1'b1);
      push_pkt(9, 2, 1'b1);
    end
    wait_drain(100, "rr");
    nout = out_cyc.size();
    vectors++;
    if (nout != 12) begin
      miscompares++;
      $display("FAIL rr_count: got %0d want 12", nout);
    end else begin
      check_gaps("rr", 3, out_cyc[0] - 3, 2);
    end
  endtask

  task automatic test_backpressure();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int k = 0;
    m_axis_tready = 1'b1;
    set_enable(16'h0002);
    push_pkt(1, 8, 1'b1);
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      m_axis_tready = pat[k % 6];
      k++;
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain(20, "bp");
  endtask

  task automatic test_enable_mask();
    int n = 0;
    m_axis_tready = 1'b1;
    set_enable(16'h0004);
    out_cyc.delete();
    push_pkt(7, 5, 1'b0);
    push_pkt(2, 5, 1'b1);
    while (out_cyc.size() < 1 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    channel_enable = '0;
    wait_drain(50, "mask");
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (src_q[7].size() != 5) begin
      miscompares++;
      $display("FAIL mask_ch7: got %0d beats taken want 0", 5 - src_q[7].size());
    end
    vectors++;
    if (s_axis_tready !== '0) begin
      miscompares++;
      $display("FAIL mask_idle_ready: got %h want 0", s_axis_tready);
    end
    src_q[7].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    m_axis_tready = 1'b1;
    set_enable(16'h0010);
    out_cyc.delete();
    push_pkt(4, 6, 1'b1);
    while (out_cyc.size() < 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      miscompares++;
      $display("FAIL midreset_out: got v=%b d=%h want v=0 d=0", m_axis_tvalid, m_axis_tdata);
    end
    vectors++;
    if (s_axis_tready !== '0) begin
      miscompares++;
      $display("FAIL midreset_sready: got %h want 0", s_axis_tready);
    end
    clear_queues();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    push_pkt(4, 2, 1'b1);
    wait_drain(50, "midreset");
  endtask

  task automatic test_back_to_back();
    int nout;
    m_axis_tready = 1'b1;
    set_enable(16'hFFFF);
    out_cyc.delete();
    push_pkt(6, 1, 1'b1);
    push_pkt(8, 1, 1'b1);
    wait_drain(50, "b2b");
    nout = out_cyc.size();
    vectors++;
    if (nout != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 2", nout);
    end else begin
      vectors++;
      if (out_cyc[1] - out_cyc[0] != 2) begin
        miscompares++;
        $display("FAIL b2b_gap: got %0d want 2", out_cyc[1] - out_cyc[0]);
      end
    end
  endtask

  initial begin
    channel_enable = '0;
    m_axis_tready  = 1'b0;
    resetn         = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_enable_mask();
    test_reset_mid_packet();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_collector.md
Name: axis_collector

Overview:
- Reverse path of the PS-to-channel router. Merges up to 16 per-channel AXI-Stream sources into one 256-bit stream toward the PL-to-PS module.
- Round-robin arbitration runs at packet granularity. A grant locks to one channel until that channel's tlast beat is accepted.
- The source channel index is tagged on tuser so software can demultiplex.
- Output is a single registered stage that sustains full throughput.

Parameters:
- NUM_CH, 16, number of input channels.
- DATA_W, 256, tdata width per channel.
- IDX_W, 4, width of the channel index; equals clog2(NUM_CH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- channel_enable  in  NUM_CH  per-channel arbitration enable; registered once internally before use.
- s_axis_tdata  in  NUM_CH*DATA_W  concatenated channel data; channel i occupies [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  DATA_W  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tuser  out  IDX_W  source channel index of the current beat.
- m_axis_tready  in  1  downstream ready.

Behaviour:
Reset (resetn low, asynchronous):
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
- s_axis_tready=0.
- State=IDLE, grant=0, rr_ptr=NUM_CH-1, enable register=0.
- Deassertion takes effect on the next clk edge.

Enable register:
- en_q <= channel_enable every cycle. Arbitration uses en_q only, so a new enable takes effect 1 cycle later.

State IDLE:
- s_axis_tready all 0.
- Request vector req = s_axis_tvalid & en_q.
- If req != 0: grant <= first set bit searching upward from rr_ptr+1, wrapping modulo NUM_CH. State <= LOCKED.
- If req == 0: remain in IDLE.

State LOCKED:
- out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready[grant] = out_free; every other bit is 0. This is combinational from state, grant, m_axis_tvalid and m_axis_tready.
- On a beat accepted from grant (tvalid & tready): the output register loads tdata, tlast, tuser=grant, and m_axis_tvalid <= 1.
- If that beat has tlast=1: rr_ptr <= grant, state <= IDLE.

Output register:
- When m_axis_tready=1 and no new beat loads, m_axis_tvalid <= 0.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable (AXIS rule).

Latency and throughput:
- An input beat appears on m_axis 1 cycle after acceptance.
- Within a packet: 1 beat per cycle.
- Between packets: exactly 1 idle arbitration cycle.

Boundary conditions:
- Channel disabled mid-packet: the grant holds until that packet's tlast. Packets are never truncated or interleaved.
- Single-beat packet (tvalid and tlast in the same beat): LOCKED lasts 1 cycle, then IDLE.
- Granted source drops tvalid mid-packet: the block waits indefinitely in LOCKED. No timeout.
- Simultaneous requests: only the round-robin order decides. No fixed priority beyond the rr_ptr start.
- rr_ptr wraps from NUM_CH-1 to 0.
- Reset mid-packet: the partial packet is discarded and outputs clear immediately. After release, the upstream source must restart its packet.
- An m_axis_tready toggle in the cycle the last beat is loaded must not duplicate or drop the beat.

Test Plan:
1. Single packet, channel 3: en=0x0008; channel 3 sends 4 beats D0..D3 with tlast on D3; m_axis_tready=1 → m_axis carries D0..D3 on consecutive cycles, tuser=3 on every beat, tlast only on D3, first output 2 cycles after tvalid rises.
2. Round robin after reset: en=0xFFFF; channels 0, 5, 9 each continuously offer 2-beat packets → output packet order 0,5,9,0,5,9, with 1 idle cycle between packets.
3. Backpressure: channel 1 sends 8 beats; m_axis_tready follows pattern 1,0,0,1,1,0,... → all 8 beats out in order with none lost or duplicated; m_axis_* stable while stalled; s_axis_tready[1] low whenever the output is full and stalled.
4. Enable masking: en=0x0004; channels 2 and 7 both valid → only channel 2 granted. Clear en bit 2 during beat 2 of a 5-beat packet → all 5 beats delivered, then no further grants.
5. Reset mid-packet: assert resetn=0 after beat 2 of 6 from channel 4 → m_axis_tvalid=0 and s_axis_tready=0 asynchronously. After release, a 2-beat packet from channel 4 is granted first, since rr_ptr=15.
